decoder_iter_ctrl: RTL and testbench
====================================

# decoder_iter_ctrl

Sequencing controller for the unrolled-in-time min-sum decoder: accepts one codeword of channel LLRs over a valid/ready handshake, then drives a single combinational intermediate layer (variable + check nodes with per-iteration LUT biases) for N_ITER iterations, feeding each iteration's edge messages back as the next iteration's input. It owns the LLR and edge-message registers, the iteration counter and the bias index. After the last iteration it presents the final edge messages downstream over a second valid/ready handshake.

## Interface
- WIDTH, 8: bits per LLR / edge message (two's complement)
- N_V, 16: variable nodes (LLRs per codeword)
- E, 48: Tanner-graph edges
- N_ITER, 5: iterations per codeword; 1 ≤ N_ITER ≤ number of bias LUT entries
- CNT_W, $clog2(N_ITER+1): iteration counter width
- clk  in  1  sole clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream codeword valid
- in_ready  out  1  controller can accept a codeword
- in_llrs  in  WIDTH*N_V  channel LLRs, sampled on in_valid && in_ready
- layer_bias_idx  out  `INT_SIZE  bias LUT index for the current iteration
- layer_llrs  out  WIDTH*N_V  registered LLRs to the layer
- layer_prev  out  WIDTH*E  registered edge messages to the layer
- layer_proc  in  WIDTH*E  layer output (combinational from layer_prev/layer_llrs/layer_bias_idx)
- out_valid  out  1  final messages available
- out_ready  in  1  downstream accepts
- out_proc_elem  out  WIDTH*E  final edge messages (= msg_q)
- out_iters  out  CNT_W  iterations actually executed for this codeword
- busy  out  1  high in RUN or DONE

## Operation
- Registers: llr_q (WIDTH*N_V), msg_q (WIDTH*E), iter_q (CNT_W), state.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid: llr_q<=in_llrs, msg_q<=0, iter_q<=0, → RUN. No in_valid: hold.
- RUN: in_ready=0. Each cycle msg_q<=layer_proc, iter_q<=iter_q+1. When iter_q==N_ITER-1 at the edge → DONE (iter_q becomes N_ITER).
- DONE: out_valid=1, in_ready=0. On out_ready → IDLE; msg_q, llr_q, iter_q hold until next accept.
- layer_bias_idx = iter_q zero-extended to `INT_SIZE; layer_llrs = llr_q; layer_prev = msg_q.
- out_iters = iter_q; out_proc_elem = msg_q (valid only while out_valid).
- No arithmetic on messages in this block; layer_proc stored verbatim (saturation belongs to the layer).
- Upstream must hold in_llrs stable only during the accepting cycle.
- in_valid in RUN/DONE ignored (in_ready=0); no queuing, no overlap between codewords.
- out_ready in IDLE/RUN ignored.

## Timing
- Reset (rst=1 at edge): state=IDLE, llr_q=0, msg_q=0, iter_q=0 → in_ready=1, out_valid=0, busy=0, layer_bias_idx=0, out_iters=0. Reset overrides all, including mid-RUN and mid-DONE; codeword in flight is discarded.
- Accept at edge T0; layer evaluated during cycles T0+1..T0+N_ITER; out_valid first high in the cycle after edge T0+N_ITER.
- Latency accept→out_valid: N_ITER cycles. Min throughput period: N_ITER+2 cycles (1 IDLE + N_ITER RUN + ≥1 DONE).
- in_ready is registered-state driven (Moore); no combinational path from out_ready to in_ready.
- N_ITER=1: RUN lasts one cycle.

## Configuration
- ITER_EARLY_STOP_EN defined: in RUN, if layer_proc == msg_q (bitwise, all E messages) and iter_q ≥ 1, msg_q keeps value, iter_q<=iter_q+1, → DONE immediately; out_iters reports iterations executed including the converged one. The N_ITER limit still applies.
- Undefined: comparator absent; always exactly N_ITER iterations; out_iters always N_ITER in DONE.

## Test plan
- Reset then idle: rst 2 cycles → in_ready=1, out_valid=0, busy=0, layer_bias_idx=0, out_iters=0.
- Single codeword, N_ITER=5, layer model returning msg+1 per edge: accept at T0 → layer_bias_idx 0,1,2,3,4 in cycles T0+1..T0+5; out_valid in cycle T0+6; every edge of out_proc_elem = 5; out_iters=5.
- Backpressure: out_ready=0 for 10 cycles in DONE → out_valid, out_proc_elem stable, in_ready=0, in_valid pulses ignored; out_ready=1 → IDLE next cycle, in_ready=1.
- Back-to-back: in_valid held high, out_ready held high → accepts every 7 cycles (N_ITER=5), each result matches its own input LLRs.
- Reset mid-RUN at iteration 2 → next cycle IDLE, msg_q=0, out_valid never asserted for that codeword.
- ITER_EARLY_STOP_EN defined, layer model constant after iteration 1: out_valid after 2 iterations (accept-to-out_valid latency 2), out_iters=2; undefined: out_iters=5.

Source files
------------

// File: rtl/decoder_iter_ctrl.sv
// Purpose : iteration sequencer for the unrolled min-sum decoder; owns LLR/message registers and iteration count.
// Latency : N_ITER cycles from codeword accept to out_valid (fewer with ITER_EARLY_STOP_EN on convergence).
// Backpressure: one codeword in flight; in_ready low in RUN/DONE, DONE holds results until out_ready.
//
// Optional feature macro: ITER_EARLY_STOP_EN -- stop iterating once the layer output equals the
// stored messages (after at least one iteration). Undefined: always exactly N_ITER iterations.
//
// Ports:
//   clk, rst                    sole clock, synchronous active-high reset
//   in_valid/in_ready/in_llrs   codeword input handshake (LLRs sampled on accept)
//   layer_bias_idx/llrs/prev    drive the external combinational layer
//   layer_proc                  layer result, stored verbatim each RUN cycle
//   out_valid/out_ready         result handshake; out_proc_elem/out_iters are the results
//   busy                        high while a codeword occupies the controller

`ifndef INT_SIZE
`define INT_SIZE 32
`endif

module decoder_iter_ctrl #(
    parameter int WIDTH  = 8,
    parameter int N_V    = 16,
    parameter int E      = 48,
    parameter int N_ITER = 5,
    parameter int CNT_W  = $clog2(N_ITER + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH*N_V-1:0] in_llrs,
    output logic [`INT_SIZE-1:0] layer_bias_idx,
    output logic [WIDTH*N_V-1:0] layer_llrs,
    output logic [WIDTH*E-1:0]   layer_prev,
    input  logic [WIDTH*E-1:0]   layer_proc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH*E-1:0]   out_proc_elem,
    output logic [CNT_W-1:0]     out_iters,
    output logic                 busy
);

    localparam int BIAS_W = `INT_SIZE;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [WIDTH*N_V-1:0] llr_q;
    logic [WIDTH*E-1:0]   msg_q;
    logic [CNT_W-1:0]     iter_q;
    logic                 converged;

`ifdef ITER_EARLY_STOP_EN
    // The first iteration always runs from an all-zero message set, so a
    // match there says nothing about convergence; require iter_q >= 1.
    assign converged = (state_q == RUN) && (iter_q != '0) && (layer_proc == msg_q);
`else
    assign converged = 1'b0;
`endif

    // State register plus the datapath registers it sequences.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            llr_q   <= '0;
            msg_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        llr_q  <= in_llrs;
                        msg_q  <= '0;
                        iter_q <= '0;
                    end
                end
                RUN: begin
                    // On convergence the layer output already equals msg_q.
                    if (!converged) begin
                        msg_q <= layer_proc;
                    end
                    iter_q <= iter_q + CNT_W'(1);
                end
                default: begin
                    // DONE: results hold until the next accept.
                end
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if ((iter_q == LAST_ITER) || converged) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs: handshake flags depend on registered state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            RUN:     busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign layer_bias_idx = BIAS_W'(iter_q);
    assign layer_llrs     = llr_q;
    assign layer_prev     = msg_q;
    assign out_proc_elem  = msg_q;
    assign out_iters      = iter_q;

endmodule

// File: tb/tb_decoder_iter_ctrl.sv
`ifndef INT_SIZE
`define INT_SIZE 32
`endif

module tb_decoder_iter_ctrl;

    localparam int WIDTH  = 8;
    localparam int N_V    = 16;
    localparam int E      = 48;
    localparam int N_ITER = 5;
    localparam int CNT_W  = $clog2(N_ITER + 1);
`ifdef ITER_EARLY_STOP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH*N_V-1:0] in_llrs;
    logic [`INT_SIZE-1:0] layer_bias_idx;
    logic [WIDTH*N_V-1:0] layer_llrs;
    logic [WIDTH*E-1:0]   layer_prev;
    logic [WIDTH*E-1:0]   layer_proc;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH*E-1:0]   out_proc_elem;
    logic [CNT_W-1:0]     out_iters;
    logic                 busy;

    int total = 0;
    int bad   = 0;
    int mode  = 0;   // 0: msg+1, 1: msg+llr+bias, 2: constant llr

    decoder_iter_ctrl #(
        .WIDTH(WIDTH), .N_V(N_V), .E(E), .N_ITER(N_ITER), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_llrs(in_llrs),
        .layer_bias_idx(layer_bias_idx), .layer_llrs(layer_llrs),
        .layer_prev(layer_prev), .layer_proc(layer_proc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_proc_elem(out_proc_elem), .out_iters(out_iters), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external layer: one byte rule per edge.
    function automatic logic [WIDTH-1:0] edge_fn(input int md, input logic [WIDTH-1:0] prev,
                                                 input logic [WIDTH-1:0] llr, input logic [WIDTH-1:0] bias);
        case (md)
            0:       return prev + WIDTH'(1);
            1:       return prev + llr + bias;
            default: return llr;
        endcase
    endfunction

    always_comb begin
        layer_proc = '0;
        for (int e = 0; e < E; e++) begin
            layer_proc[e*WIDTH +: WIDTH] = edge_fn(mode, layer_prev[e*WIDTH +: WIDTH],
                                                   layer_llrs[(e % N_V)*WIDTH +: WIDTH],
                                                   layer_bias_idx[WIDTH-1:0]);
        end
    end

    // Reference: iterate the layer rule on message arrays, apply the stop rules.
    task automatic ref_run(input logic [WIDTH*N_V-1:0] llrs, input int md,
                           output logic [WIDTH*E-1:0] msgs, output int iters);
        logic [WIDTH-1:0] m [E];
        logic [WIDTH-1:0] nx [E];
        bool_same: begin end
        for (int e = 0; e < E; e++) m[e] = '0;
        iters = 0;
        for (int it = 0; it < N_ITER; it++) begin
            bit same;
            same = 1'b1;
            for (int e = 0; e < E; e++) begin
                nx[e] = edge_fn(md, m[e], llrs[(e % N_V)*WIDTH +: WIDTH], WIDTH'(it));
                if (nx[e] != m[e]) same = 1'b0;
            end
            iters++;
            if (EARLY && it >= 1 && same) break;
            for (int e = 0; e < E; e++) m[e] = nx[e];
        end
        msgs = '0;
        for (int e = 0; e < E; e++) msgs[e*WIDTH +: WIDTH] = m[e];
    endtask

    task automatic check(input string tag, input logic [WIDTH*E-1:0] obs, input logic [WIDTH*E-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH*N_V-1:0] rand_llrs();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [WIDTH*E-1:0]   exp_msgs;
        logic [WIDTH*E-1:0]   held_msgs;
        logic [WIDTH*N_V-1:0] held_llrs;
        logic [WIDTH*N_V-1:0] q [$];
        int exp_iters;
        int acc, res, last_acc, cyc, lat;
        bit seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_llrs = '0; mode = 0;

        // Reset then idle.
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_bias", layer_bias_idx, 0);
        check("rst_iters", out_iters, 0);
        tick();
        check("idle_hold_in_ready", in_ready, 1);

        // Single codeword, layer adds 1 per iteration.
        mode = 0;
        in_llrs = rand_llrs();
        held_llrs = in_llrs;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_llrs = rand_llrs();
        check("run_in_ready", in_ready, 0);
        check("run_busy", busy, 1);
        check("run_llrs", layer_llrs, held_llrs);
        for (int k = 0; k < N_ITER; k++) begin
            check($sformatf("bias_idx_%0d", k), layer_bias_idx, k);
            check($sformatf("run_out_valid_%0d", k), out_valid, 0);
            tick();
        end
        for (int e = 0; e < E; e++) exp_msgs[e*WIDTH +: WIDTH] = WIDTH'(N_ITER);
        check("single_out_valid", out_valid, 1);
        check("single_msgs", out_proc_elem, exp_msgs);
        check("single_iters", out_iters, N_ITER);

        // Backpressure in DONE with ignored in_valid pulses.
        held_msgs = out_proc_elem;
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid = $urandom_range(0, 1);
            in_llrs = rand_llrs();
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_msgs", out_proc_elem, held_msgs);
            check("bp_in_ready", in_ready, 0);
            check("bp_llrs", layer_llrs, held_llrs);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);
        check("release_busy", busy, 0);

        // Back-to-back: in_valid and out_ready held high.
        mode = 1;
        acc = 0; res = 0; last_acc = -1; cyc = 0;
        in_llrs = rand_llrs();
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (res < 3 && cyc < 300) begin
            if (in_valid && in_ready) begin
                q.push_back(in_llrs);
                if (last_acc >= 0) check("b2b_period", cyc - last_acc, N_ITER + 2);
                last_acc = cyc;
                acc++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("b2b_unexpected_result", 1, 0);
                end else begin
                    ref_run(q.pop_front(), 1, exp_msgs, exp_iters);
                    check("b2b_msgs", out_proc_elem, exp_msgs);
                    check("b2b_iters", out_iters, exp_iters);
                end
                res++;
            end
            tick();
            cyc++;
            in_llrs = rand_llrs();
            if (acc >= 3) in_valid = 1'b0;
        end
        if (res < 3) check("b2b_timeout", res, 3);
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_idle", in_ready, 1);

        // Reset mid-RUN at iteration 2.
        mode = 0;
        in_llrs = rand_llrs();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("midrun_bias", layer_bias_idx, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_in_ready", in_ready, 1);
        check("midrun_busy", busy, 0);
        check("midrun_msg", layer_prev, 0);
        check("midrun_bias0", layer_bias_idx, 0);
        seen = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        check("midrun_no_out", seen, 0);

        // Layer output constant after the first iteration.
        mode = 2;
        in_llrs = rand_llrs();
        held_llrs = in_llrs;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        ref_run(held_llrs, 2, exp_msgs, exp_iters);
        check("const_latency", lat, EARLY ? 2 : N_ITER);
        check("const_iters", out_iters, EARLY ? 2 : N_ITER);
        check("const_iters_model", out_iters, exp_iters);
        check("const_msgs", out_proc_elem, exp_msgs);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("const_release", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
